// File: rtl/cavlc_level_ctrl_pkg.sv
// State codes shared between the CAVLC level sequencer and the level-decoding datapath,
// plus the prefix bit-count helper.
package cavlc_level_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_TRAILING_SIGN = 4'd1,
    ST_LEVEL_PREFIX  = 4'd2,
    ST_LEVEL_SUFFIX  = 4'd3,
    ST_LEVEL_DONE    = 4'd4
  } cavlc_state_e;

  // A prefix of N leading zeros is followed by its terminating one; prefix 15 consumes 16 bits.
  function automatic logic [4:0] prefix_bits(input logic [3:0] leading_zeros);
    return {1'b0, leading_zeros} + 5'd1;
  endfunction

endpackage

// File: rtl/cavlc_level_ctrl.sv
// CAVLC level-decoding sequencer: walks the datapath through trailing-ones signs and
// prefix/suffix pairs, tracks the level index and reports bits consumed per cycle.
module cavlc_level_ctrl
  import cavlc_level_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] TotalCoeff,
  input  logic [1:0] TrailingOnes,
  input  logic [3:0] heading_one_pos,
  input  logic [3:0] levelSuffixSize,
  input  logic       bs_valid,
  output logic [3:0] cavlc_decoder_state,
  output logic [3:0] i_level,
  output logic       suffix_length_initialized,
  output logic [4:0] bits_consumed,
  output logic       busy,
  output logic       done
);

  cavlc_state_e state_q, state_nxt;
  logic [3:0]   i_level_q, i_level_nxt;
  logic         flag_q, flag_nxt;
  logic         busy_q, busy_nxt;
  logic         done_q, done_nxt;
  logic         last_level;

  assign last_level = ({1'b0, i_level_q} == (TotalCoeff - 5'd1));

  always_comb begin
    state_nxt     = state_q;
    i_level_nxt   = i_level_q;
    flag_nxt      = flag_q;
    bits_consumed = 5'd0;
    if (abort) begin
      state_nxt   = ST_IDLE;
      i_level_nxt = 4'd0;
      flag_nxt    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            i_level_nxt = 4'd0;
            flag_nxt    = 1'b0;
            if (TotalCoeff == 5'd0)
              state_nxt = ST_LEVEL_DONE;
            else if (TrailingOnes != 2'd0)
              state_nxt = ST_TRAILING_SIGN;
            else
              state_nxt = ST_LEVEL_PREFIX;
          end
        end
        ST_TRAILING_SIGN: begin
          if (bs_valid) begin
            bits_consumed = {3'b000, TrailingOnes};
            i_level_nxt   = {2'b00, TrailingOnes};
            state_nxt     = (TotalCoeff == {3'b000, TrailingOnes}) ? ST_LEVEL_DONE
                                                                   : ST_LEVEL_PREFIX;
          end
        end
        ST_LEVEL_PREFIX: begin
          // The datapath reads the flag while in this state, so it only rises on exit.
          if (bs_valid) begin
            bits_consumed = prefix_bits(heading_one_pos);
            flag_nxt      = 1'b1;
            state_nxt     = ST_LEVEL_SUFFIX;
          end
        end
        ST_LEVEL_SUFFIX: begin
          if (bs_valid) begin
            bits_consumed = {1'b0, levelSuffixSize};
            if (last_level) begin
              state_nxt = ST_LEVEL_DONE;
            end else begin
              i_level_nxt = i_level_q + 4'd1;
              state_nxt   = ST_LEVEL_PREFIX;
            end
          end
        end
        ST_LEVEL_DONE: state_nxt = ST_IDLE;
        default:       state_nxt = ST_IDLE;
      endcase
    end
  end

  // An empty block (straight from Idle to Done) never reports busy.
  assign busy_nxt = (state_nxt != ST_IDLE) &&
                    !((state_nxt == ST_LEVEL_DONE) && (state_q == ST_IDLE));
  assign done_nxt = (state_nxt == ST_LEVEL_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      i_level_q <= 4'd0;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      i_level_q <= i_level_nxt;
      flag_q    <= flag_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign cavlc_decoder_state       = state_q;
  assign i_level                   = i_level_q;
  assign suffix_length_initialized = flag_q;
  assign busy                      = busy_q;
  assign done                      = done_q;

endmodule

// File: tb/tb_cavlc_level_ctrl.sv
// Scoreboard bench for cavlc_level_ctrl: expected per-cycle outputs are queued by the
// stimulus and popped by a monitor whenever the sequencer is out of Idle or pulses done.
module tb_cavlc_level_ctrl;
  import cavlc_level_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, bs_valid;
  logic [4:0] TotalCoeff;
  logic [1:0] TrailingOnes;
  logic [3:0] heading_one_pos, levelSuffixSize;
  logic [3:0] cavlc_decoder_state, i_level;
  logic       suffix_length_initialized, busy, done;
  logic [4:0] bits_consumed;

  cavlc_level_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
    .heading_one_pos(heading_one_pos), .levelSuffixSize(levelSuffixSize),
    .bs_valid(bs_valid), .cavlc_decoder_state(cavlc_decoder_state), .i_level(i_level),
    .suffix_length_initialized(suffix_length_initialized),
    .bits_consumed(bits_consumed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] lvl;
    logic       flag;
    logic [4:0] bits;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  logic vld_seq[$];
  logic abt_seq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: one expected record per cycle the DUT is active.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && reset_n && (cavlc_decoder_state != ST_IDLE || done)) begin
      if (done) done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output state %0d done %0d with empty scoreboard",
                 cavlc_decoder_state, done);
      end else begin
        e = exp_q.pop_front();
        chk("state", int'(cavlc_decoder_state), int'(e.st));
        chk("i_level", int'(i_level), int'(e.lvl));
        chk("suffix_flag", int'(suffix_length_initialized), int'(e.flag));
        chk("bits_consumed", int'(bits_consumed), int'(e.bits));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
      end
    end
  end

  task automatic add_state(input logic [3:0] st, input int lvl, input bit flag, input int bits,
                           input bit bsy, input int stall_pos, input int stall_len,
                           input int abort_pos, inout int pos, inout bit stop);
    exp_t e;
    if (stop) return;
    pos++;
    e.st = st; e.lvl = 4'(lvl); e.flag = flag; e.busy = bsy; e.done = 1'b0; e.bits = 5'd0;
    if (pos == stall_pos) begin
      for (int s = 0; s < stall_len; s++) begin
        exp_q.push_back(e); vld_seq.push_back(1'b0); abt_seq.push_back(1'b0);
      end
    end
    if (pos == abort_pos) begin
      exp_q.push_back(e); vld_seq.push_back(1'b1); abt_seq.push_back(1'b1);
      stop = 1'b1;
    end else begin
      e.bits = 5'(bits);
      e.done = (st == ST_LEVEL_DONE);
      exp_q.push_back(e); vld_seq.push_back(1'b1); abt_seq.push_back(1'b0);
    end
  endtask

  task automatic run_block(input int tc, input int t1, input int hop, input int lss,
                           input int stall_pos, input int stall_len, input int abort_pos,
                           input bit start_glitch, input int latency);
    int pos = 0;
    bit stop = 1'b0;
    bit flag = 1'b0;
    int start_cyc;
    vld_seq.delete();
    abt_seq.delete();
    if (tc == 0) begin
      add_state(ST_LEVEL_DONE, 0, 0, 0, 0, stall_pos, stall_len, abort_pos, pos, stop);
    end else begin
      if (t1 != 0)
        add_state(ST_TRAILING_SIGN, 0, 0, t1, 1, stall_pos, stall_len, abort_pos, pos, stop);
      for (int k = t1; k < tc; k++) begin
        add_state(ST_LEVEL_PREFIX, k, flag, hop + 1, 1, stall_pos, stall_len, abort_pos, pos, stop);
        flag = 1'b1;
        add_state(ST_LEVEL_SUFFIX, k, 1, lss, 1, stall_pos, stall_len, abort_pos, pos, stop);
      end
      add_state(ST_LEVEL_DONE, (tc == t1) ? t1 : tc - 1, flag, 0, 1,
                stall_pos, stall_len, abort_pos, pos, stop);
    end
    TotalCoeff = 5'(tc); TrailingOnes = 2'(t1);
    heading_one_pos = 4'(hop); levelSuffixSize = 4'(lss);
    bs_valid = 1'b1; abort = 1'b0;
    done_cyc = -1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < vld_seq.size(); j++) begin
      bs_valid = vld_seq[j];
      abort    = abt_seq[j];
      start    = start_glitch && (j == 1);
      @(posedge clk); #1;
    end
    abort = 1'b0; bs_valid = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("back_to_idle", int'(cavlc_decoder_state), int'(ST_IDLE));
    if (abort_pos == 0) begin
      chk("latency", done_cyc - start_cyc, latency);
    end else begin
      chk("no_done_after_abort", done_cyc, -1);
      chk("i_level_after_abort", int'(i_level), 0);
      chk("flag_after_abort", int'(suffix_length_initialized), 0);
    end
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; bs_valid = 1'b0;
    TotalCoeff = '0; TrailingOnes = '0; heading_one_pos = '0; levelSuffixSize = '0;
    #12;
    chk("rst_state", int'(cavlc_decoder_state), int'(ST_IDLE));
    chk("rst_i_level", int'(i_level), 0);
    chk("rst_flag", int'(suffix_length_initialized), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bits", int'(bits_consumed), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Empty block, all-trailing-ones block, mixed block, mixed with stall and stray start.
    run_block(0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_block(3, 3, 0, 0, 0, 0, 0, 0, 2);
    run_block(5, 1, 2, 1, 0, 0, 0, 0, 10);
    run_block(5, 1, 2, 1, 3, 3, 0, 1, 13);
    // Longest prefix and suffix, then a full 16-coefficient block.
    run_block(1, 0, 15, 12, 0, 0, 0, 0, 3);
    run_block(16, 0, 0, 0, 0, 0, 0, 0, 33);
    // Abort in the LevelSuffix holding i_level=2, then a fresh block.
    run_block(5, 1, 2, 1, 0, 0, 5, 0, 0);
    run_block(2, 0, 1, 3, 0, 0, 0, 0, 5);

    // start together with abort in Idle.
    TotalCoeff = 5'd4; TrailingOnes = 2'd0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_state", int'(cavlc_decoder_state), int'(ST_IDLE));
    chk("start_abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("start_abort_still_idle", int'(cavlc_decoder_state), int'(ST_IDLE));

    // Asynchronous reset mid-block.
    mon_en = 1'b0;
    TotalCoeff = 5'd5; TrailingOnes = 2'd1; bs_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_state", int'(cavlc_decoder_state), int'(ST_IDLE));
    chk("areset_i_level", int'(i_level), 0);
    chk("areset_done", int'(done), 0);
    chk("areset_busy", int'(busy), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("areset_stays_idle", int'(cavlc_decoder_state), int'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
